pet_need_engine: RTL and testbench

- Parametrised successor to the pet state controller: owns N independent need channels (energy, hunger, entertainment, …) with per-channel decay/refill timing.
- Each channel has a saturating level; the block derives a mood classification with a death-grace timer from the levels.
- Sits between the button debouncers and the sprite/display selector; the display consumes `mood`, `stats` and `neediest`.
- Replaces the hard-wired three-stat logic. One shared tick timebase removes the multi-driver counter hazard.

---
 rtl/pet_pkg.sv | 16 +
 rtl/need_channel.sv | 71 +++++++
 rtl/pet_need_engine.sv | 159 +++++++++++++++
 tb/tb_pet_need_engine.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pet_pkg.sv
// rtl/pet_pkg.sv - shared mood encodings and need-channel indices for the pet need engine
package pet_pkg;

  typedef enum logic [2:0] {
    MOOD_IDLE    = 3'd0,
    MOOD_NEUTRAL = 3'd1,
    MOOD_NEEDY   = 3'd2,
    MOOD_SAD     = 3'd3,
    MOOD_DEATH   = 3'd4
  } mood_e;

  localparam int CH_ENERGY = 0;
  localparam int CH_HUNGER = 1;
  localparam int CH_FUN    = 2;

endpackage

// File: rtl/need_channel.sv
// rtl/need_channel.sv - one need channel: period counter, saturating level register
module need_channel #(
  parameter int               STAT_W     = 3,
  parameter int               STAT_MAX   = 5,
  parameter int               PER_W      = 16,
  parameter logic [PER_W-1:0] DECAY_PER  = 16'd4,
  parameter logic [PER_W-1:0] REFILL_PER = 16'd2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic              freeze_i,
  input  logic              refill_en_i,
  input  logic              refill_pulse_i,
  output logic [STAT_W-1:0] level_o
);

  localparam int                      SW      = STAT_W + 2;
  localparam logic signed [SW-1:0]    MAX_S   = SW'(STAT_MAX);
  localparam logic [PER_W-1:0]        DEC_LIM = DECAY_PER - 1'b1;
  localparam logic [PER_W-1:0]        REF_LIM = REFILL_PER - 1'b1;

  logic [PER_W-1:0]     cnt_q, cnt_d, limit;
  logic                 en_q;
  logic [STAT_W-1:0]    level_q, level_d;
  logic                 en_change, at_limit, decay_ev, refill_ev;
  logic signed [SW-1:0] sum;

  // Period counter and saturating level arithmetic; a mode change restarts the period.
  always_comb begin
    limit     = refill_en_i ? REF_LIM : DEC_LIM;
    en_change = refill_en_i ^ en_q;
    at_limit  = tick_i && !en_change && (cnt_q == limit);
    decay_ev  = at_limit && !refill_en_i;
    refill_ev = at_limit && refill_en_i;

    cnt_d = cnt_q;
    if (en_change || at_limit) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + 1'b1;
    end

    sum = $signed({2'b00, level_q}) + $signed(SW'(refill_ev))
        + $signed(SW'(refill_pulse_i)) - $signed(SW'(decay_ev));

    if (sum[SW-1]) begin
      level_d = '0;
    end else if (sum > MAX_S) begin
      level_d = STAT_W'(STAT_MAX);
    end else begin
      level_d = sum[STAT_W-1:0];
    end
  end

  // Channel state registers; everything holds while frozen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      en_q    <= 1'b0;
      level_q <= STAT_W'(STAT_MAX);
    end else if (!freeze_i) begin
      cnt_q   <= cnt_d;
      en_q    <= refill_en_i;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/pet_need_engine.sv
// rtl/pet_need_engine.sv - N-channel need engine: tick base, zero timer, neediest encoder, mood FSM
module pet_need_engine
  import pet_pkg::*;
#(
  parameter int                         N_NEEDS     = 3,
  parameter int                         STAT_W      = 3,
  parameter int                         STAT_MAX    = 5,
  parameter int                         LOW_TH      = 2,
  parameter int                         TICK_DIV    = 50000,
  parameter int                         PER_W       = 16,
  parameter logic [N_NEEDS*PER_W-1:0]   DECAY_PER   = {16'd8, 16'd2, 16'd4},
  parameter logic [N_NEEDS*PER_W-1:0]   REFILL_PER  = {16'd1, 16'd1, 16'd2},
  parameter int                         DEATH_TICKS = 16,
  localparam int                        IDX_W       = (N_NEEDS > 1) ? $clog2(N_NEEDS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pause,
  input  logic [N_NEEDS-1:0]          refill_en,
  input  logic [N_NEEDS-1:0]          refill_pulse,
  output logic [N_NEEDS*STAT_W-1:0]   stats,
  output logic [N_NEEDS-1:0]          low_mask,
  output logic [IDX_W-1:0]            neediest,
  output logic [2:0]                  mood,
  output logic                        mood_chg,
  output logic                        dead
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ZW    = (DEATH_TICKS > 0) ? $clog2(DEATH_TICKS + 1) : 1;

  logic [CNT_W-1:0]  tick_cnt_q;
  logic              tick;
  logic [ZW-1:0]     zero_q;
  logic              any_zero, all_max, expired;
  logic [STAT_W-1:0] level [N_NEEDS];
  logic [N_NEEDS-1:0] low_d, low_mask_q;
  logic [IDX_W-1:0]  need_d, neediest_q;
  logic [STAT_W-1:0] best;
  logic              found;
  int                pop;
  mood_e             mood_q, mood_d;
  logic              mood_chg_q, dead_q;

  assign tick = !pause && !dead_q && (tick_cnt_q == CNT_W'(TICK_DIV - 1));

  // Shared tick timebase; holds its phase while paused or dead.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (!pause && !dead_q) begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
    end
  end

  for (genvar g = 0; g < N_NEEDS; g++) begin : g_ch
    need_channel #(
      .STAT_W    (STAT_W),
      .STAT_MAX  (STAT_MAX),
      .PER_W     (PER_W),
      .DECAY_PER (DECAY_PER[g*PER_W +: PER_W]),
      .REFILL_PER(REFILL_PER[g*PER_W +: PER_W])
    ) u_ch (
      .clk_i         (clk),
      .rst_i         (rst),
      .tick_i        (tick),
      .freeze_i      (dead_q),
      .refill_en_i   (refill_en[g]),
      .refill_pulse_i(refill_pulse[g]),
      .level_o       (level[g])
    );
    assign stats[g*STAT_W +: STAT_W] = level[g];
  end

  // Level summaries, low mask and lowest-level low channel (ties to the lower index).
  always_comb begin
    any_zero = 1'b0;
    all_max  = 1'b1;
    low_d    = '0;
    need_d   = '0;
    best     = STAT_W'(STAT_MAX);
    found    = 1'b0;
    for (int i = 0; i < N_NEEDS; i++) begin
      if (level[i] == '0) any_zero = 1'b1;
      if (level[i] != STAT_W'(STAT_MAX)) all_max = 1'b0;
      low_d[i] = (level[i] <= STAT_W'(LOW_TH));
      if (low_d[i] && (!found || level[i] < best)) begin
        found  = 1'b1;
        best   = level[i];
        need_d = IDX_W'(i);
      end
    end
  end

  // Registered low mask and neediest index.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_mask_q <= '0;
      neediest_q <= '0;
    end else begin
      low_mask_q <= low_d;
      neediest_q <= need_d;
    end
  end

  // Zero timer: counts ticks while any level is empty, saturates at the death threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= '0;
    end else if (!dead_q) begin
      if (!any_zero) begin
        zero_q <= '0;
      end else if (tick && zero_q < ZW'(DEATH_TICKS)) begin
        zero_q <= zero_q + 1'b1;
      end
    end
  end

  assign expired = any_zero && (zero_q >= ZW'(DEATH_TICKS));

  // Mood decision from registered levels and low mask; DEATH is absorbing.
  always_comb begin
    pop = 0;
    for (int i = 0; i < N_NEEDS; i++) begin
      pop = pop + int'(low_mask_q[i]);
    end
    if (mood_q == MOOD_DEATH || expired) begin
      mood_d = MOOD_DEATH;
    end else if (all_max) begin
      mood_d = MOOD_IDLE;
    end else if (pop >= 2) begin
      mood_d = MOOD_SAD;
    end else if (pop == 1) begin
      mood_d = MOOD_NEEDY;
    end else begin
      mood_d = MOOD_NEUTRAL;
    end
  end

  // Mood FSM with registered change pulse and dead flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      mood_q     <= MOOD_IDLE;
      mood_chg_q <= 1'b0;
      dead_q     <= 1'b0;
    end else begin
      mood_q     <= mood_d;
      mood_chg_q <= (mood_d != mood_q);
      dead_q     <= (mood_d == MOOD_DEATH);
    end
  end

  assign low_mask = low_mask_q;
  assign neediest = neediest_q;
  assign mood     = mood_q;
  assign mood_chg = mood_chg_q;
  assign dead     = dead_q;

endmodule

// File: tb/tb_pet_need_engine.sv
// tb/tb_pet_need_engine.sv - directed table-driven bench for pet_need_engine
module tb_pet_need_engine;

  logic       clk;
  logic       rst;
  logic       pause;
  logic [2:0] refill_en;
  logic [2:0] refill_pulse;
  logic [8:0] stats;
  logic [2:0] low_mask;
  logic [1:0] neediest;
  logic [2:0] mood;
  logic       mood_chg;
  logic       dead;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  typedef struct {
    int         at;
    logic [8:0] stats;
    logic [2:0] low;
    logic [1:0] need;
    logic [2:0] mood;
    logic       chg;
    logic       dead;
  } vec_t;

  vec_t tbl[15];

  pet_need_engine #(
    .TICK_DIV   (4),
    .DEATH_TICKS(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pause       (pause),
    .refill_en   (refill_en),
    .refill_pulse(refill_pulse),
    .stats       (stats),
    .low_mask    (low_mask),
    .neediest    (neediest),
    .mood        (mood),
    .mood_chg    (mood_chg),
    .dead        (dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input int at, input logic [8:0] st, input logic [2:0] lo,
                              input logic [1:0] nd, input logic [2:0] md, input logic ch,
                              input logic dd);
    vec_t v;
    v.at = at; v.stats = st; v.low = lo; v.need = nd; v.mood = md; v.chg = ch; v.dead = dd;
    return v;
  endfunction

  function automatic logic [2:0] lvl(input int ch);
    return stats[ch*3 +: 3];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step_to(input int target);
    while (edge_n < target) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; refill_en = 3'b000; refill_pulse = 3'b000;
    step_to(2);

    // stats in octal: digits are channel 2, 1, 0
    tbl[0]  = mk(0,  9'o555, 3'b000, 2'd0, 3'd0, 1'b0, 1'b0);
    tbl[1]  = mk(7,  9'o555, 3'b000, 2'd0, 3'd0, 1'b0, 1'b0);
    tbl[2]  = mk(8,  9'o545, 3'b000, 2'd0, 3'd0, 1'b0, 1'b0);
    tbl[3]  = mk(9,  9'o545, 3'b000, 2'd0, 3'd1, 1'b1, 1'b0);
    tbl[4]  = mk(10, 9'o545, 3'b000, 2'd0, 3'd1, 1'b0, 1'b0);
    tbl[5]  = mk(24, 9'o524, 3'b000, 2'd0, 3'd1, 1'b0, 1'b0);
    tbl[6]  = mk(25, 9'o524, 3'b010, 2'd1, 3'd1, 1'b0, 1'b0);
    tbl[7]  = mk(26, 9'o524, 3'b010, 2'd1, 3'd2, 1'b1, 1'b0);
    tbl[8]  = mk(40, 9'o403, 3'b010, 2'd1, 3'd2, 1'b0, 1'b0);
    tbl[9]  = mk(49, 9'o402, 3'b011, 2'd1, 3'd2, 1'b0, 1'b0);
    tbl[10] = mk(50, 9'o402, 3'b011, 2'd1, 3'd3, 1'b1, 1'b0);
    tbl[11] = mk(52, 9'o402, 3'b011, 2'd1, 3'd3, 1'b0, 1'b0);
    tbl[12] = mk(53, 9'o402, 3'b011, 2'd1, 3'd4, 1'b1, 1'b1);
    tbl[13] = mk(54, 9'o402, 3'b011, 2'd1, 3'd4, 1'b0, 1'b1);
    tbl[14] = mk(70, 9'o402, 3'b011, 2'd1, 3'd4, 1'b0, 1'b1);

    // Free-running decay to SAD and DEATH
    do_reset();
    for (int r = 0; r < 15; r++) begin
      step_to(tbl[r].at);
      chk($sformatf("e%0d stats", tbl[r].at), 32'(stats),    32'(tbl[r].stats));
      chk($sformatf("e%0d low",   tbl[r].at), 32'(low_mask), 32'(tbl[r].low));
      chk($sformatf("e%0d need",  tbl[r].at), 32'(neediest), 32'(tbl[r].need));
      chk($sformatf("e%0d mood",  tbl[r].at), 32'(mood),     32'(tbl[r].mood));
      chk($sformatf("e%0d chg",   tbl[r].at), 32'(mood_chg), 32'(tbl[r].chg));
      chk($sformatf("e%0d dead",  tbl[r].at), 32'(dead),     32'(tbl[r].dead));
    end

    // Pulses in DEATH are ignored
    refill_pulse = 3'b111;
    step_to(71);
    refill_pulse = 3'b000;
    step_to(73);
    chk("death pulse stats", 32'(stats), 32'(9'o402));
    chk("death hold", 32'(dead), 32'd1);

    // Reset out of DEATH
    do_reset();
    chk("rst stats", 32'(stats), 32'(9'o555));
    chk("rst mood", 32'(mood), 32'd0);
    chk("rst chg", 32'(mood_chg), 32'd0);
    chk("rst dead", 32'(dead), 32'd0);
    chk("rst low", 32'(low_mask), 32'd0);
    step_to(3);
    chk("post rst chg", 32'(mood_chg), 32'd0);
    chk("post rst mood", 32'(mood), 32'd0);

    // Saturation and pulse/decay coincidence
    refill_pulse = 3'b100;
    step_to(1);
    refill_pulse = 3'b000;
    chk("pulse at max", 32'(lvl(2)), 32'd5);
    step_to(16);
    chk("ch1 before coincide", 32'(lvl(1)), 32'd3);
    step_to(23);
    refill_pulse = 3'b010;
    step_to(24);
    refill_pulse = 3'b000;
    chk("pulse+decay net0", 32'(lvl(1)), 32'd3);
    refill_pulse = 3'b010;
    step_to(25);
    refill_pulse = 3'b000;
    chk("pulse alone", 32'(lvl(1)), 32'd4);
    chk("ch0 decay", 32'(lvl(0)), 32'd4);

    // Recovery from zero before the death threshold
    do_reset();
    step_to(40);
    chk("rec ch1 zero", 32'(lvl(1)), 32'd0);
    step_to(49);
    refill_pulse = 3'b010;
    step_to(50);
    refill_pulse = 3'b000;
    chk("rec ch1 one", 32'(lvl(1)), 32'd1);
    step_to(53);
    chk("rec no death e53", 32'(dead), 32'd0);
    step_to(55);
    chk("rec mood sad", 32'(mood), 32'd3);
    chk("rec no death e55", 32'(dead), 32'd0);
    step_to(56);
    chk("rec ch1 zero again", 32'(lvl(1)), 32'd0);

    // Pause freezes the timebase, pulses still apply
    do_reset();
    step_to(10);
    pause = 1'b1;
    step_to(19);
    chk("pause stats", 32'(stats), 32'(9'o545));
    chk("pause mood", 32'(mood), 32'd1);
    refill_pulse = 3'b010;
    step_to(20);
    refill_pulse = 3'b000;
    chk("pause pulse", 32'(stats), 32'(9'o555));
    step_to(30);
    pause = 1'b0;
    step_to(32);
    chk("resume e32", 32'(stats), 32'(9'o555));
    step_to(35);
    chk("resume e35", 32'(stats), 32'(9'o555));
    step_to(36);
    chk("resume e36", 32'(stats), 32'(9'o544));

    // Tie on neediest, then refill mode on channel 2
    refill_en = 3'b011;
    do_reset();
    step_to(50);
    refill_en = 3'b010;
    step_to(96);
    chk("tie ch0", 32'(lvl(0)), 32'd2);
    chk("tie ch2", 32'(lvl(2)), 32'd2);
    step_to(97);
    chk("tie low", 32'(low_mask), 32'(3'b101));
    chk("tie need", 32'(neediest), 32'd0);
    step_to(98);
    chk("tie mood sad", 32'(mood), 32'd3);
    refill_en = 3'b110;
    step_to(99);
    chk("refill e99", 32'(lvl(2)), 32'd2);
    step_to(100);
    chk("refill e100", 32'(lvl(2)), 32'd3);
    step_to(104);
    chk("refill e104", 32'(lvl(2)), 32'd4);
    step_to(108);
    chk("refill e108", 32'(lvl(2)), 32'd5);
    step_to(112);
    chk("refill sat e112", 32'(lvl(2)), 32'd5);
    refill_en = 3'b011;
    step_to(143);
    chk("decay restart e143", 32'(lvl(2)), 32'd5);
    step_to(144);
    chk("decay restart e144", 32'(lvl(2)), 32'd4);
    chk("alive", 32'(dead), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
